alu_mul_seq: RTL and testbench



---
 rtl/alu_mul_seq.sv | 112 +++++++++++
 tb/tb_alu_mul_seq.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/alu_mul_seq.sv
// alu_mul_seq: request/response sequencer that drives an external ALU for single ops and shift-and-add multiply.
module alu_mul_seq #(
    parameter int N_ITER = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic       req_mul,
    input  logic [2:0] req_op,
    input  logic [7:0] req_a,
    input  logic [7:0] req_b,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic [7:0] rsp_data,
    output logic       rsp_zero,
    output logic       busy,
    output logic [7:0] alu_input_a,
    output logic [7:0] alu_input_b,
    output logic [2:0] alu_opcode,
    input  logic [7:0] alu_out,
    input  logic       zero
);
    typedef enum logic [2:0] {IDLE, SINGLE, MUL_ADD, MUL_SHL, DONE} state_t;
    state_t     state_q, state_d;
    logic [7:0] acc_q, acc_d, mcand_q, mcand_d, mplier_q, mplier_d, rsp_data_q, rsp_data_d;
    logic [2:0] op_q, op_d;
    logic [3:0] cnt_q, cnt_d;
    logic       rsp_zero_q, rsp_zero_d;
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            acc_q      <= '0;
            mcand_q    <= '0;
            mplier_q   <= '0;
            op_q       <= '0;
            cnt_q      <= '0;
            rsp_data_q <= '0;
            rsp_zero_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            acc_q      <= acc_d;
            mcand_q    <= mcand_d;
            mplier_q   <= mplier_d;
            op_q       <= op_d;
            cnt_q      <= cnt_d;
            rsp_data_q <= rsp_data_d;
            rsp_zero_q <= rsp_zero_d;
        end
    end
    // mcand/mplier double as the captured A/B operands of a single op
    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        mcand_d     = mcand_q;
        mplier_d    = mplier_q;
        op_d        = op_q;
        cnt_d       = cnt_q;
        rsp_data_d  = rsp_data_q;
        rsp_zero_d  = rsp_zero_q;
        alu_opcode  = 3'b000;
        alu_input_a = 8'd0;
        alu_input_b = 8'd0;
        case (state_q)
            IDLE: if (req_valid) begin
                mcand_d  = req_a;
                mplier_d = req_b;
                op_d     = req_op;
                acc_d    = 8'd0;
                cnt_d    = 4'd0;
                state_d  = req_mul ? MUL_ADD : SINGLE;
            end
            SINGLE: begin
                alu_opcode  = op_q;
                alu_input_a = mcand_q;
                alu_input_b = mplier_q;
                rsp_data_d  = alu_out;
                rsp_zero_d  = zero;
                state_d     = DONE;
            end
            MUL_ADD: begin
                alu_opcode  = 3'b001;
                alu_input_a = acc_q;
                alu_input_b = mcand_q;
                acc_d       = mplier_q[0] ? alu_out : acc_q;
                state_d     = MUL_SHL;
            end
            MUL_SHL: begin
                alu_opcode  = 3'b100;
                alu_input_a = mcand_q;
                alu_input_b = 8'd1;
                mcand_d     = alu_out;
                mplier_d    = mplier_q >> 1;
                cnt_d       = cnt_q + 4'd1;
                if (cnt_q == 4'(N_ITER - 1)) begin
                    rsp_data_d = acc_q;
                    rsp_zero_d = (acc_q == 8'd0);
                    state_d    = DONE;
                end else begin
                    state_d = MUL_ADD;
                end
            end
            DONE: state_d = rsp_ready ? IDLE : DONE;
            default: state_d = IDLE;
        endcase
    end
    assign req_ready = (state_q == IDLE) & ~reset;
    assign rsp_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign rsp_data  = rsp_data_q;
    assign rsp_zero  = rsp_zero_q;
endmodule

// File: tb/tb_alu_mul_seq.sv
// tb_alu_mul_seq: random and directed checks of alu_mul_seq against a behavioural ALU and product model.
module tb_alu_mul_seq;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       req_valid = 1'b0, req_ready, req_mul = 1'b0;
    logic [2:0] req_op = '0;
    logic [7:0] req_a = '0, req_b = '0;
    logic       rsp_valid, rsp_ready = 1'b1, rsp_zero, busy, zero;
    logic [7:0] rsp_data, alu_input_a, alu_input_b, alu_out;
    logic [2:0] alu_opcode;
    int         n_checks = 0, n_fail = 0;

    alu_mul_seq dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
        .req_mul(req_mul), .req_op(req_op), .req_a(req_a), .req_b(req_b),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_zero(rsp_zero), .busy(busy), .alu_input_a(alu_input_a),
        .alu_input_b(alu_input_b), .alu_opcode(alu_opcode), .alu_out(alu_out), .zero(zero)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] alu_f(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
        case (op)
            3'b000:  return a & b;
            3'b001:  return a + b;
            3'b010:  return a ^ b;
            3'b011:  return a | b;
            3'b100:  return a << b[2:0];
            3'b101:  return a >> b[2:0];
            3'b110:  return a - b;
            default: return b;
        endcase
    endfunction

    assign alu_out = alu_f(alu_opcode, alu_input_a, alu_input_b);
    assign zero    = (alu_out == 8'd0);

    function automatic logic [7:0] ref_res(input logic mul, input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
        int p;
        p = int'(a) * int'(b);
        return mul ? p[7:0] : alu_f(op, a, b);
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Called at a negedge with the block idle; completes the response handshake.
    task automatic run(input string tag, input logic mul, input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
        int lat, bad;
        logic [7:0] e;
        e = ref_res(mul, op, a, b);
        check({tag, ".req_ready"}, req_ready, 1);
        req_valid = 1'b1; req_mul = mul; req_op = op; req_a = a; req_b = b;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        lat = 0; bad = 0;
        while (!rsp_valid && lat < 100) begin
            if (mul && alu_opcode !== ((lat % 2 == 0) ? 3'b001 : 3'b100)) bad++;
            @(negedge clk);
            lat++;
        end
        check({tag, ".latency"}, lat, mul ? 16 : 1);
        check({tag, ".data"}, rsp_data, e);
        check({tag, ".zero"}, rsp_zero, e == 8'd0);
        if (mul) check({tag, ".opseq"}, bad, 0);
        rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check({tag, ".rsp_valid_drop"}, rsp_valid, 0);
        check({tag, ".idle_ready"}, req_ready, 1);
    endtask

    initial begin
        logic [7:0] held;
        int lat;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset.req_ready", req_ready, 0);
        check("reset.busy", busy, 0);
        check("reset.rsp_valid", rsp_valid, 0);
        check("reset.rsp_data", rsp_data, 0);
        check("reset.rsp_zero", rsp_zero, 0);
        reset = 1'b0;
        @(negedge clk);

        run("add7f01", 1'b0, 3'b001, 8'h7F, 8'h01);
        run("xor5a", 1'b0, 3'b010, 8'h5A, 8'h5A);
        run("mul13x11", 1'b1, 3'b000, 8'd13, 8'd11);
        run("mulffff", 1'b1, 3'b111, 8'hFF, 8'hFF);
        run("mul10x10", 1'b1, 3'b000, 8'h10, 8'h10);
        run("mul0xa5", 1'b1, 3'b000, 8'h00, 8'hA5);

        // backpressure: response held while rsp_ready is low, requests dropped
        rsp_ready = 1'b0;
        req_valid = 1'b1; req_mul = 1'b0; req_op = 3'b011; req_a = 8'h12; req_b = 8'h40;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        lat = 0;
        while (!rsp_valid && lat < 100) begin @(negedge clk); lat++; end
        check("bp.latency", lat, 1);
        held = rsp_data;
        check("bp.data", held, 8'h52);
        for (int i = 0; i < 5; i++) begin
            req_valid = i[0]; req_mul = 1'b1; req_a = 8'($urandom); req_b = 8'($urandom);
            @(posedge clk);
            @(negedge clk);
            check("bp.hold_valid", rsp_valid, 1);
            check("bp.hold_data", rsp_data, 8'h52);
            check("bp.req_ready", req_ready, 0);
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("bp.released", rsp_valid, 0);
        check("bp.no_queued", busy, 0);

        // reset after three multiply iterations
        req_valid = 1'b1; req_mul = 1'b1; req_a = 8'd9; req_b = 8'd9;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        repeat (5) @(negedge clk);
        check("rst_mid.busy_before", busy, 1);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("rst_mid.busy", busy, 0);
        check("rst_mid.rsp_valid", rsp_valid, 0);
        check("rst_mid.rsp_data", rsp_data, 0);
        reset = 1'b0;
        @(negedge clk);
        run("mul3x5", 1'b1, 3'b000, 8'd3, 8'd5);

        run("b2b_and", 1'b0, 3'b000, 8'hF0, 8'h3C);
        run("b2b_mul", 1'b1, 3'b000, 8'd2, 8'd7);

        for (int i = 0; i < 20; i++)
            run("rand", 1'($urandom), 3'($urandom), 8'($urandom), 8'($urandom));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end
endmodule
